// File: rtl/mult_factor_pkg.sv
// Shared types and constants for the factor-search engine: FSM states,
// minimum operand values and the per-pair cycle cost.
package mult_factor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MUL,
    CHECK,
    EMIT,
    DONE
  } state_t;

  localparam int A_MIN = 2;
  localparam int B_MIN = 2;

  // LOAD + B_W multiply steps + CHECK
  function automatic int pair_cycles(input int b_w);
    return b_w + 2;
  endfunction

endpackage

// File: rtl/seq_shift_add_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, B_W cycles
// after a load. o_last flags the final step, o_done pulses with the result.
module seq_shift_add_mul #(
  parameter int A_W = 4,
  parameter int B_W = 3,
  parameter int P_W = A_W + B_W
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_load,
  input  logic [A_W-1:0] i_a,
  input  logic [B_W-1:0] i_b,
  output logic           o_busy,
  output logic           o_last,
  output logic           o_done,
  output logic [P_W-1:0] o_prod
);

  localparam int SW = (B_W > 1) ? $clog2(B_W) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(B_W - 1);

  logic [P_W-1:0] r_acc;
  logic [B_W-1:0] r_mreg;
  logic [SW-1:0]  r_step;
  logic           r_busy;
  logic           r_done;
  logic [P_W-1:0] w_addend;

  assign w_addend = P_W'(i_a) << r_step;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc  <= '0;
      r_mreg <= '0;
      r_step <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_load) begin
        r_acc  <= '0;
        r_mreg <= i_b;
        r_step <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (r_mreg[0]) r_acc <= r_acc + w_addend;
        r_mreg <= r_mreg >> 1;
        if (r_step == LAST_STEP) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_step <= r_step + SW'(1);
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_last = r_busy && (r_step == LAST_STEP);
  assign o_done = r_done;
  assign o_prod = r_acc;

endmodule

// File: rtl/mult_factor_search.sv
// Exhaustive factor search: enumerates (a, b) >= 2, streams every a*b == T.
// Optional MULT_FACTOR_PRUNE_EN skips the rest of a row once a*b exceeds T.
module mult_factor_search
  import mult_factor_pkg::*;
#(
  parameter int A_W   = 4,
  parameter int B_W   = 3,
  parameter int P_W   = A_W + B_W,
  parameter int CNT_W = A_W + B_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [P_W-1:0]   i_target,
  output logic             o_busy,
  output logic             o_sol_valid,
  input  logic             i_sol_ready,
  output logic [A_W-1:0]   o_sol_a,
  output logic [B_W-1:0]   o_sol_b,
  output logic             o_done,
  output logic             o_sat,
  output logic [CNT_W-1:0] o_sol_count
);

  localparam logic [A_W-1:0] A_LO = A_W'(A_MIN);
  localparam logic [B_W-1:0] B_LO = B_W'(B_MIN);
  localparam logic [A_W-1:0] A_HI = '1;
  localparam logic [B_W-1:0] B_HI = '1;

  state_t           r_state;
  logic [P_W-1:0]   r_target;
  logic [A_W-1:0]   r_a;
  logic [B_W-1:0]   r_b;
  logic             r_busy;
  logic             r_sol_valid;
  logic [A_W-1:0]   r_sol_a;
  logic [B_W-1:0]   r_sol_b;
  logic             r_done;
  logic             r_sat;
  logic [CNT_W-1:0] r_sol_count;

  logic             w_mul_load;
  logic             w_mul_busy;
  logic             w_mul_last;
  logic             w_mul_done;
  logic [P_W-1:0]   w_prod;
  logic             w_b_wrap;
  logic             w_a_wrap;
  logic             w_adv_end;
  logic [A_W-1:0]   w_adv_a;
  logic [B_W-1:0]   w_adv_b;
  logic             w_hit;

  assign w_mul_load = (r_state == LOAD);
  assign w_b_wrap   = (r_b == B_HI);
  assign w_a_wrap   = (r_a == A_HI);
  assign w_adv_end  = w_b_wrap && w_a_wrap;
  assign w_adv_a    = w_b_wrap ? r_a + A_W'(1) : r_a;
  assign w_adv_b    = w_b_wrap ? B_LO : r_b + B_W'(1);
  assign w_hit      = w_mul_done && (w_prod == r_target);

`ifdef MULT_FACTOR_PRUNE_EN
  logic w_over;
  // products grow with b, so once past T the rest of this row cannot match
  assign w_over = w_mul_done && (w_prod > r_target);
`endif

  seq_shift_add_mul #(
    .A_W(A_W),
    .B_W(B_W),
    .P_W(P_W)
  ) u_mul (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_mul_load),
    .i_a    (r_a),
    .i_b    (r_b),
    .o_busy (w_mul_busy),
    .o_last (w_mul_last),
    .o_done (w_mul_done),
    .o_prod (w_prod)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_target    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_busy      <= 1'b0;
      r_sol_valid <= 1'b0;
      r_sol_a     <= '0;
      r_sol_b     <= '0;
      r_done      <= 1'b0;
      r_sat       <= 1'b0;
      r_sol_count <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_abort && (r_state != IDLE)) begin
        r_state     <= IDLE;
        r_busy      <= 1'b0;
        r_sol_valid <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_start) begin
              r_target    <= i_target;
              r_sat       <= 1'b0;
              r_sol_count <= '0;
              r_a         <= A_LO;
              r_b         <= B_LO;
              r_busy      <= 1'b1;
              r_state     <= LOAD;
            end
          end
          LOAD: r_state <= MUL;
          MUL: begin
            if (w_mul_busy && w_mul_last) r_state <= CHECK;
          end
          CHECK: begin
            if (w_hit) begin
              r_sol_valid <= 1'b1;
              r_sol_a     <= r_a;
              r_sol_b     <= r_b;
              r_state     <= EMIT;
            end
`ifdef MULT_FACTOR_PRUNE_EN
            else if (w_over) begin
              if (w_a_wrap) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= DONE;
              end else begin
                r_a     <= r_a + A_W'(1);
                r_b     <= B_LO;
                r_state <= LOAD;
              end
            end
`endif
            else if (w_adv_end) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_a     <= w_adv_a;
              r_b     <= w_adv_b;
              r_state <= LOAD;
            end
          end
          EMIT: begin
            if (i_sol_ready) begin
              r_sol_valid <= 1'b0;
              r_sat       <= 1'b1;
              if (r_sol_count != '1) r_sol_count <= r_sol_count + CNT_W'(1);
              if (w_adv_end) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= DONE;
              end else begin
                r_a     <= w_adv_a;
                r_b     <= w_adv_b;
                r_state <= LOAD;
              end
            end
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_sol_valid = r_sol_valid;
  assign o_sol_a     = r_sol_a;
  assign o_sol_b     = r_sol_b;
  assign o_done      = r_done;
  assign o_sat       = r_sat;
  assign o_sol_count = r_sol_count;

endmodule

// File: doc/mult_factor_search.md
Name: mult_factor_search

Overview:
- Sequential, parametrised successor to the fixed-width combinational multiplier-factorisation SAT checks.
- Latches a runtime target T and exhaustively enumerates operand pairs (a, b) with a >= 2 and b >= 2.
- Multiplies each pair with a shift-add multiplier and streams every pair with a*b == T out on a valid/ready port.
- Used as a hardware reference and ground-truth oracle for the multiplier_factorize SAT benchmarks on the FPGA-CSAT platform.

Parameters:
- A_W, 4, width of operand a (>= 2)
- B_W, 3, width of operand b (>= 2)
- P_W, A_W+B_W, product/target width (derived; do not override)
- CNT_W, A_W+B_W, solution counter width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle request; accepted only in IDLE
- abort  in  1  cancel the search; returns to IDLE next cycle
- target  in  P_W  value to factor; sampled on an accepted start
- busy  out  1  high from the cycle after start acceptance until the done pulse or abort
- sol_valid  out  1  solution available
- sol_ready  in  1  consumer accepts the solution
- sol_a  out  A_W  factor a of the current solution
- sol_b  out  B_W  factor b of the current solution
- done  out  1  one-cycle pulse when enumeration completes
- sat  out  1  sticky: at least one solution found since the last start
- sol_count  out  CNT_W  number of solutions emitted since the last start (saturating)

Behaviour:
- Reset: all outputs 0, FSM in IDLE, internal registers cleared.
- Enumeration order: a outer, b inner, both ascending. a runs 2..2^A_W-1, b runs 2..2^B_W-1.
- start in IDLE latches target into T, clears sat and sol_count, sets a=2, b=2, and moves to LOAD. start in any other state is ignored.
- FSM states and per-pair cost (B_W+2 cycles per pair):
  - LOAD, 1 cycle: accumulator = 0, multiplier register = b.
  - MUL, exactly B_W cycles: per cycle, if multiplier LSB is 1 then acc += a << step; multiplier shifts right; acc is P_W bits, with no overflow by construction.
  - CHECK, 1 cycle: if acc == T, go to EMIT; otherwise advance the pair.
- EMIT:
  - sol_valid = 1 with sol_a/sol_b stable while sol_ready = 0.
  - On the handshake cycle (valid & ready): sat <= 1, sol_count++ (saturates at all-ones), then advance the pair.
  - A minimum of 1 cycle is spent in EMIT.
- Advance: b++. If b wraps past 2^B_W-1, b = 2 and a++. If a wraps past 2^A_W-1, go to DONE; otherwise go to LOAD.
- DONE: done = 1 for one cycle, busy = 0, then IDLE. sat and sol_count hold until the next start.
- abort (any non-IDLE state, highest priority after rst): next cycle IDLE, busy = 0, sol_valid = 0, no done pulse, sat/sol_count keep their values. abort in IDLE has no effect.
- Target 0 or 1, or T > (2^A_W-1)*(2^B_W-1): full enumeration still runs, zero solutions, done fires.
- Latency, no solutions, no prune: done is asserted (2^A_W-2)*(2^B_W-2)*(B_W+2)+1 cycles after the start cycle. Each emitted solution adds its EMIT cycles.

Optional Feature:
- Macro: MULT_FACTOR_PRUNE_EN.
- Defined: in CHECK, if acc > T, skip the remaining b values for the current a (b = 2, a++). The solution set and order are identical to the unpruned search; the cycle count is reduced.
- Undefined: no early skip; cycle count is exactly as stated in Behaviour.

Decomposition:
- Shared package mult_factor_pkg: FSM state enum (IDLE, LOAD, MUL, CHECK, EMIT, DONE), the A_MIN/B_MIN = 2 constants, and a helper function for the per-pair cycle cost.
- One sub-module, seq_shift_add_mul (load/busy/done, B_W-cycle iterative multiply), instantiated once.

Test Plan:
- A_W=4, B_W=3, target=25, sol_ready=1 -> exactly one solution (5,5); sat=1, sol_count=1; done at cycle 421 after start plus the EMIT cycle.
- target=24 -> solutions in order (4,6), (6,4), (8,3), (12,2); sol_count=4, sat=1.
- target=13 (prime) -> no sol_valid, sat=0, sol_count=0; done exactly 421 cycles after start (prune off).
- target=24, hold sol_ready=0 for 10 cycles at the first solution -> sol_valid stays high, sol_a=4, sol_b=6 stable, no further progress; released -> remaining 3 solutions follow.
- abort 50 cycles after start, then rst asserted mid-search in a second run -> IDLE next cycle (async for rst), busy=0, no done, outputs at reset values after rst; a new start afterwards behaves as a fresh run.
- MULT_FACTOR_PRUNE_EN defined, target=24 -> same 4 solutions in the same order, done strictly earlier than in the unpruned run.
